// File: rtl/modulo_varredura_coord_at_pkg.sv
// Shared types and constants for the coordinate scanner.
// Holds the FSM state type, coordinate width and default scan geometry.
package modulo_varredura_coord_at_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_HOLD,
      ST_DONE
   } state_t;

   localparam int COORD_W   = 3;
   localparam int CNT_W     = 8;
   localparam int N_COL_DEF = 5;
   localparam int N_ROW_DEF = 7;
   localparam int DWELL_DEF = 4;

   function automatic logic [COORD_W-1:0] coord_max(input int n);
      return COORD_W'(n - 1);
   endfunction

endpackage

// File: rtl/modulo_varredura_coord_at_contador.sv
// Loadable down-counter with zero flag, used to time the dwell
// period of each coordinate.
module modulo_contador_dwell_at
   import modulo_varredura_coord_at_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load has priority; decrement saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/modulo_varredura_coord_at.sv
// Row-major coordinate scanner with valid/ack handoff and dwell timer.
// Optional macro SCAN_CONTINUOUS_EN restarts the frame at (0,0) forever.
module modulo_varredura_coord_at
   import modulo_varredura_coord_at_pkg::*;
#(
   parameter int N_COL = N_COL_DEF,
   parameter int N_ROW = N_ROW_DEF,
   parameter int DWELL = DWELL_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               ack,
   output logic [COORD_W-1:0] mdc,
   output logic [COORD_W-1:0] mdl,
   output logic               coord_valid,
   output logic               busy,
   output logic               frame_done
);

   localparam logic [COORD_W-1:0] COL_MAX  = coord_max(N_COL);
   localparam logic [COORD_W-1:0] ROW_MAX  = coord_max(N_ROW);
   localparam logic [CNT_W-1:0]   DWELL_LD = CNT_W'(DWELL - 1);

   state_t             state_q, state_d;
   logic [COORD_W-1:0] mdc_q, mdc_d;
   logic [COORD_W-1:0] mdl_q, mdl_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               fdone_q, fdone_d;
   logic               cnt_load;
   logic               cnt_dec;
   logic               cnt_zero;
   logic               col_last;
   logic               row_last;

   assign col_last = (mdc_q == COL_MAX);
   assign row_last = (mdl_q == ROW_MAX);

   modulo_contador_dwell_at u_dwell (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (DWELL_LD),
      .zero     (cnt_zero)
   );

   // Next-state and next-output logic for the scan FSM.
   always_comb begin
      state_d  = state_q;
      mdc_d    = mdc_q;
      mdl_d    = mdl_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      fdone_d  = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_DRIVE;
               mdc_d   = '0;
               mdl_d   = '0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         ST_DRIVE: begin
            if (ack) begin
               state_d  = ST_HOLD;
               valid_d  = 1'b0;
               cnt_load = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else if (col_last && row_last) begin
               state_d = ST_DONE;
               mdc_d   = '0;
               mdl_d   = '0;
               fdone_d = 1'b1;
`ifdef SCAN_CONTINUOUS_EN
               busy_d  = 1'b1;
`else
               busy_d  = 1'b0;
`endif
            end else begin
               state_d = ST_DRIVE;
               valid_d = 1'b1;
               if (col_last) begin
                  mdc_d = '0;
                  mdl_d = mdl_q + COORD_W'(1);
               end else begin
                  mdc_d = mdc_q + COORD_W'(1);
               end
            end
         end
         ST_DONE: begin
`ifdef SCAN_CONTINUOUS_EN
            state_d = ST_DRIVE;
            valid_d = 1'b1;
`else
            state_d = ST_IDLE;
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mdc_q   <= '0;
         mdl_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         fdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mdc_q   <= mdc_d;
         mdl_q   <= mdl_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         fdone_q <= fdone_d;
      end
   end

   assign mdc         = mdc_q;
   assign mdl         = mdl_q;
   assign coord_valid = valid_q;
   assign busy        = busy_q;
   assign frame_done  = fdone_q;

endmodule

// File: doc/modulo_varredura_coord_at.md
MODULO_VARREDURA_COORD_AT -- requirements
Module: modulo_varredura_coord_at

Interface
REQ-001 N_COL, 5, number of columns scanned; mdc range 0..N_COL-1, max 8.
REQ-002 N_ROW, 7, number of rows scanned; mdl range 0..N_ROW-1, max 8.
REQ-003 DWELL, 4, clock cycles each coordinate is held after acceptance, 1..255.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle pulse requesting a frame scan.
REQ-007 ack  input  1  consumer (1-of-4 selector path) accepts current coordinate.
REQ-008 mdc  output  3  column coordinate presented to the selector.
REQ-009 mdl  output  3  row coordinate presented to the selector.
REQ-010 coord_valid  output  1  mdc/mdl are valid and stable.
REQ-011 busy  output  1  high from frame start until frame end.
REQ-012 frame_done  output  1  one-cycle pulse after the last coordinate's dwell expires.

Function
REQ-013 FSM states: IDLE, DRIVE, HOLD, DONE; encoding is free.
REQ-014 IDLE: start=1 -> DRIVE next cycle, mdc=0, mdl=0, busy=1; start ignored in all other states.
REQ-015 DRIVE: coord_valid=1; mdc/mdl do not change while coord_valid=1 and ack=0.
REQ-016 DRIVE with ack=1: transfer completes on that edge; -> HOLD, coord_valid=0, dwell counter loaded with DWELL-1.
REQ-017 HOLD: counter decrements each cycle; mdc/mdl unchanged; at counter 0, advance coordinate and go to DRIVE, or to DONE after the last coordinate.
REQ-018 Scan order row-major: mdc increments 0..N_COL-1; on wrap mdc=0 and mdl increments; last coordinate is (N_COL-1, N_ROW-1).
REQ-019 DONE: frame_done=1 for exactly one cycle, busy=0, -> IDLE.
REQ-020 Latency: start to first coord_valid = 1 cycle; ack to next coord_valid = DWELL+1 cycles; full frame with ack tied high = N_COL*N_ROW*(DWELL+1)+2 cycles start to frame_done.
REQ-021 ack while coord_valid=0 has no effect.
REQ-022 Coordinates never leave their ranges; counter arithmetic is 3-bit with explicit compare to N_COL-1/N_ROW-1, no natural overflow.
REQ-023 start coincident with frame_done is ignored (FSM in DONE).

Reset
REQ-024 rst=1 forces, asynchronously: state IDLE, mdc=0, mdl=0, coord_valid=0, busy=0, frame_done=0, dwell counter 0.
REQ-025 rst mid-frame aborts scan; no frame_done issued; a new start is required after rst deasserts.

Configuration
REQ-026 Macro SCAN_CONTINUOUS_EN: when defined, DONE -> DRIVE at (0,0) with busy held 1, frame_done still pulsed; scan stops only by rst.
REQ-027 Without SCAN_CONTINUOUS_EN: DONE -> IDLE per REQ-019.

Structure
REQ-028 Shared package holds the FSM state typedef, coordinate width constant (3) and default N_COL/N_ROW.
REQ-029 One sub-module, modulo_contador_dwell_at: loadable down-counter with zero flag; coordinate counters stay in the top.

Verification
REQ-030 rst pulse during HOLD at (2,3) -> all outputs 0 immediately, state IDLE, no frame_done.
REQ-031 start, ack tied 1, DWELL=4 -> 35 coordinates in row-major order, frame_done at cycle 177 after start, busy low next cycle.
REQ-032 ack held 0 for 10 cycles at (0,0) -> coord_valid=1, mdc=0, mdl=0 stable throughout; advances 5 cycles after ack.
REQ-033 start pulsed while busy at (3,1) -> scan continues unchanged, single frame_done.
REQ-034 SCAN_CONTINUOUS_EN defined -> after (4,6) dwell, frame_done pulse and coord_valid at (0,0) next cycle, busy stays 1.
REQ-035 N_COL=8, N_ROW=8 -> mdc/mdl reach 7 and wrap to 0 without glitch to illegal values.
